// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dmem_pkg                                                     |
// | Description : Shared types for the data-memory responder: FSM state        |
// |               encoding, captured request record and alignment width.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  // Native data/address width of the responder slice.
  localparam int DMEM_XLEN  = 64;
  // Number of low address bits that must be zero for an aligned word access.
  localparam int ALIGN_BITS = $clog2(DMEM_XLEN / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                     write;
    logic [DMEM_XLEN-1:0]     addr;
    logic [DMEM_XLEN-1:0]     wdata;
    logic [DMEM_XLEN/8-1:0]   wstrb;
  } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_array                                                   |
// | Description : DEPTH_WORDS x XLEN word storage. Byte-strobed synchronous    |
// |               write, combinational read. Contents are never reset.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk    in  1          write clock                                        |
// |   we     in  1          write enable (qualified per byte by wstrb)         |
// |   waddr  in  ADDR_W     word index for writes                              |
// |   wdata  in  XLEN       write data                                         |
// |   wstrb  in  XLEN/8     byte enables                                       |
// |   raddr  in  ADDR_W     word index for reads                               |
// |   rdata  out XLEN       read data (combinational)                          |
// +----------------------------------------------------------------------------+
module dmem_array
  import dmem_pkg::*;
#(
  parameter int XLEN        = DMEM_XLEN,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < XLEN / 8; b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Responder side of the load/store interface. Accepts one      |
// |               request at a time, holds it for LATENCY cycles, then         |
// |               returns load data or a store ack with an error flag.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk         in  1       clock, rising edge                               |
// |   rst         in  1       synchronous reset, active-high                   |
// |   req_valid   in  1       request present                                  |
// |   req_ready   out 1       responder idle and able to accept                |
// |   req_write   in  1       1 = store, 0 = load                              |
// |   req_addr    in  XLEN    byte address                                     |
// |   req_wdata   in  XLEN    store data                                       |
// |   req_wstrb   in  XLEN/8  store byte enables                               |
// |   resp_valid  out 1       response present, held until accepted            |
// |   resp_ready  in  1       requester accepts response                       |
// |   resp_rdata  out XLEN    load data (0 for stores / errors)                |
// |   resp_err    out 1       misaligned or out-of-range request               |
// | XLEN must equal dmem_pkg::DMEM_XLEN (width of the shared request record).  |
// +----------------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = DMEM_XLEN,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int              c_idx_w      = $clog2(DEPTH_WORDS);
  localparam int              c_cnt_w      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [XLEN-1:0] c_addr_limit = XLEN'(DEPTH_WORDS * (XLEN / 8));
  // With a one-cycle latency the accept edge is also the commit edge.
  localparam bit              c_direct     = (LATENCY == 1);

  dmem_state_t        state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  dmem_req_t          req_q, req_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               err_q, err_d;

  dmem_req_t          in_req;
  dmem_req_t          cur_req;
  logic               cur_err;
  logic [c_idx_w-1:0] cur_idx;
  logic [XLEN-1:0]    arr_rdata;
  logic [XLEN-1:0]    load_val;
  logic               commit;
  logic               arr_we;

  assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // The request being committed comes straight from the ports on the accept
  // edge (LATENCY=1) and from the capture register otherwise.
  assign cur_req  = (state_q == IDLE) ? in_req : req_q;
  assign cur_err  = (|cur_req.addr[ALIGN_BITS-1:0]) || (cur_req.addr >= c_addr_limit);
  assign cur_idx  = cur_req.addr[ALIGN_BITS +: c_idx_w];
  assign load_val = (!cur_req.write && !cur_err) ? arr_rdata : '0;

  // cnt_q holds the number of WAIT cycles still to run, so the last one is 1.
  assign commit = ((state_q == IDLE) && req_valid && c_direct) ||
                  ((state_q == WAIT) && (cnt_q == c_cnt_w'(1)));
  // A reset on the commit edge cancels the store.
  assign arr_we = commit && cur_req.write && !cur_err && !rst;

  dmem_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (c_idx_w)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cur_idx),
    .wdata (cur_req.wdata),
    .wstrb (cur_req.wstrb),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          if (c_direct) begin
            state_d = RESP;
            rdata_d = load_val;
            err_d   = cur_err;
          end else begin
            state_d = WAIT;
            cnt_d   = c_cnt_w'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = RESP;
          rdata_d = load_val;
          err_d   = cur_err;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs depend on state only.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire
